multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB per instruction from opcode OP.
//  Sits beside the datapath (PC, IR, MDR, ALUOut, regfile, unified memory); drives every datapath mux/enable.
//  Adds a memory ready handshake, an optional wait timeout, JAL link and illegal-opcode trap.
// PARAMETERS
//  ALUOP_W      3  width of ALUOp; encodings R=111 ADDI=110 ANDI=011 LUI=001 ORI=101 ADD=010 SUB=100
//  MEM_TIMEOUT  0  max cycles waiting for mem_ready in FETCH/MEM_RD/MEM_WR; 0 = wait forever
//  ENABLE_JAL   1  1: JAL (6'h03) supported; 0: JAL decoded as illegal
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  OP            in   6        opcode, IR[31:26]; valid from DECODE onward
//  mem_ready     in   1        memory completes current read/write this cycle
//  PCWrite       out  1        unconditional PC load
//  PCWriteCondEQ out  1        PC load if ALU zero (BEQ)
//  PCWriteCondNE out  1        PC load if ALU not zero (BNE)
//  IorD          out  1        mem addr: 0=PC, 1=ALUOut
//  MemRead       out  1        memory read strobe, held until mem_ready
//  MemWrite      out  1        memory write strobe, held until mem_ready
//  IRWrite       out  1        load IR (=FETCH & mem_ready)
//  MemtoReg      out  2        reg write data: 00=ALUOut 01=MDR 10=PC (link)
//  RegDst        out  2        dest reg: 00=rt 01=rd 10=$ra (31)
//  RegWrite      out  1        regfile write enable
//  ALUSrcA       out  1        0=PC, 1=rs
//  ALUSrcB       out  2        00=rt 01=const 4 10=signext imm 11=signext imm<<2
//  PCSource      out  2        00=ALU result 01=ALUOut 10=jump target
//  ALUOp         out  ALUOP_W  ALU control to ALU decoder
//  state_o       out  4        current state (debug)
//  instr_done    out  1        1-cycle pulse on last state of an instruction
//  illegal_op    out  1        1-cycle pulse in DECODE on unsupported opcode
//  mem_timeout   out  1        1-cycle pulse when wait count expires
// BEHAVIOUR
//  - Reset low: state=FETCH, wait counter=0; all outputs forced 0 while reset low; first post-reset cycle is FETCH.
//  - Reset mid-instruction aborts it; no partial strobe survives the asynchronous assertion.
//  - Unlisted outputs are 0. ALUOp=010 unless stated.
//  FETCH: IorD=0 MemRead=1 ALUSrcA=0 ALUSrcB=01 PCSource=00; IRWrite=PCWrite=mem_ready. ready -> DECODE, else stay.
//  DECODE: ALUSrcA=0 ALUSrcB=11 (branch target to ALUOut). OP: 00->R_EXEC; 08/0c/0d/0f->I_EXEC;
//    23/2b->MEM_ADDR; 04/05->BRANCH; 02->JUMP; 03->JAL (if ENABLE_JAL); else illegal_op=1, instr_done=1 -> FETCH.
//  MEM_ADDR: ALUSrcA=1 ALUSrcB=10 -> MEM_RD (LW) / MEM_WR (SW).
//  MEM_RD: IorD=1 MemRead=1; ready -> MEM_WB.   MEM_WB: RegDst=00 MemtoReg=01 RegWrite=1 -> FETCH.
//  MEM_WR: IorD=1 MemWrite=1; ready -> FETCH.
//  R_EXEC: ALUSrcA=1 ALUSrcB=00 ALUOp=111 -> R_WB: RegDst=01 MemtoReg=00 RegWrite=1 -> FETCH.
//  I_EXEC: ALUSrcA=1 ALUSrcB=10 ALUOp per OP -> I_WB: RegDst=00 MemtoReg=00 RegWrite=1 -> FETCH.
//  BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=100 PCSource=01; CondEQ (04) or CondNE (05) -> FETCH.
//  JUMP: PCWrite=1 PCSource=10 -> FETCH.  JAL: JUMP outputs + RegDst=10 MemtoReg=10 RegWrite=1 -> FETCH.
//  - instr_done=1 in MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, MEM_WR&ready, illegal DECODE.
//  - Latency (mem_ready=1): R/I=4, LW=5, SW=4, BEQ/BNE/J/JAL=3 cycles.
//  - Wait counter ($clog2(MEM_TIMEOUT+1) bits): cleared on entry to FETCH/MEM_RD/MEM_WR; +1 per cycle not ready.
//    At MEM_TIMEOUT-1 and not ready: mem_timeout=1, no IRWrite/PCWrite/RegWrite, next=FETCH (refetch same PC).
//    mem_ready on the expiry cycle wins: normal completion, no mem_timeout. MEM_TIMEOUT=0 disables counter.
// STRUCTURE
//  - Package mips_ctrl_pkg: state localparams (FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 R_EXEC=6
//    R_WB=7 I_EXEC=8 I_WB=9 BRANCH=10 JUMP=11 JAL=12), opcode constants, ALUOp/mux select encodings.
//  - Sub-module: mem_wait_timer (counter + expiry flag), instantiated only when MEM_TIMEOUT>0.
// TESTING
//  - R-type OP=00, ready=1 -> states 0,1,6,7; R_WB: RegDst=01 RegWrite=1 ALUOp=111; instr_done in cycle 4.
//  - LW OP=23, ready low 2 cycles in MEM_RD -> MemRead/IorD held 3 cycles, then MEM_WB MemtoReg=01; 7 cycles total.
//  - BNE OP=05 -> BRANCH: PCWriteCondNE=1, ALUOp=100, PCSource=01; JAL OP=03 -> RegDst=10 MemtoReg=10 PCWrite=1.
//  - OP=3f (and OP=03 with ENABLE_JAL=0) -> illegal_op pulse in DECODE, next state FETCH, no RegWrite/PCWrite.
//  - MEM_TIMEOUT=4, SW with ready=0 -> mem_timeout on 4th MEM_WR cycle, -> FETCH; ready=1 on 4th cycle -> no pulse.
//  - reset low during MEM_WR -> MemWrite drops asynchronously, all outputs 0; after release FETCH, MemRead=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, ALUOp and mux selects,
// plus the packed control word the FSM drives onto the datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [2:0] ALUOP_R    = 3'b111;
    localparam logic [2:0] ALUOP_ADDI = 3'b110;
    localparam logic [2:0] ALUOP_ANDI = 3'b011;
    localparam logic [2:0] ALUOP_LUI  = 3'b001;
    localparam logic [2:0] ALUOP_ORI  = 3'b101;
    localparam logic [2:0] ALUOP_ADD  = 3'b010;
    localparam logic [2:0] ALUOP_SUB  = 3'b100;

    localparam logic [1:0] MTR_ALUOUT   = 2'b00;
    localparam logic [1:0] MTR_MDR      = 2'b01;
    localparam logic [1:0] MTR_PC       = 2'b10;
    localparam logic [1:0] RDST_RT      = 2'b00;
    localparam logic [1:0] RDST_RD      = 2'b01;
    localparam logic [1:0] RDST_RA      = 2'b10;
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_BRIMM   = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_cond_eq;
        logic       pc_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_ANDI;
            OP_ORI:  return ALUOP_ORI;
            OP_LUI:  return ALUOP_LUI;
            default: return ALUOP_ADDI;
        endcase
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state; flags expiry combinationally on the last allowed cycle.
// A ready cycle always wins over expiry, and leaving the wait state (or expiring) clears the count.
module mem_wait_timer #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    input  logic i_ready,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = i_wait && !i_ready && (r_cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_wait || i_ready || o_expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS Moore control unit; 3-5 cycles per instruction with mem_ready tied high.
// Memory stalls hold the strobes until mem_ready; an optional timeout aborts back to FETCH.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 0,
    parameter int ENABLE_JAL  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCondEQ,
    output logic               PCWriteCondNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state_o,
    output logic               instr_done,
    output logic               illegal_op,
    output logic               mem_timeout
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctl;
    logic   w_expired;
    logic   w_legal;
    logic   w_wait;

    assign w_wait = is_wait_state(r_state);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
                .clk       (clk),
                .rst_n     (reset),
                .i_wait    (w_wait),
                .i_ready   (mem_ready),
                .o_expired (w_expired)
            );
        end else begin : g_no_timer
            assign w_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        w_legal = 1'b0;
        case (OP)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: w_legal = 1'b1;
            OP_JAL:  w_legal = (ENABLE_JAL != 0);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (OP)
                    OP_RTYPE:                           w_next = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:   w_next = S_I_EXEC;
                    OP_LW, OP_SW:                       w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     w_next = S_BRANCH;
                    OP_J:                               w_next = S_JUMP;
                    OP_JAL:  w_next = (ENABLE_JAL != 0) ? S_JAL : S_FETCH;
                    default:                            w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: w_next = (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_expired) w_next = S_FETCH;
            end
            S_MEM_WR: begin
                if (mem_ready || w_expired) w_next = S_FETCH;
            end
            S_R_EXEC: w_next = S_R_WB;
            S_I_EXEC: w_next = S_I_WB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctl        = '0;
        w_ctl.alu_op = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ctl.mem_read  = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                w_ctl.pc_source = PCSRC_ALU;
                w_ctl.ir_write  = mem_ready;
                w_ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_ctl.alu_src_b  = SRCB_BRIMM;
                w_ctl.illegal_op = !w_legal;
                w_ctl.instr_done = !w_legal;
            end
            S_MEM_ADDR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                w_ctl.iord     = 1'b1;
                w_ctl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                w_ctl.reg_dst    = RDST_RT;
                w_ctl.mem_to_reg = MTR_MDR;
                w_ctl.reg_write  = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                w_ctl.iord       = 1'b1;
                w_ctl.mem_write  = 1'b1;
                w_ctl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_RT;
                w_ctl.alu_op    = ALUOP_R;
            end
            S_R_WB: begin
                w_ctl.reg_dst    = RDST_RD;
                w_ctl.mem_to_reg = MTR_ALUOUT;
                w_ctl.reg_write  = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = imm_alu_op(OP);
            end
            S_I_WB: begin
                w_ctl.reg_dst    = RDST_RT;
                w_ctl.mem_to_reg = MTR_ALUOUT;
                w_ctl.reg_write  = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a  = 1'b1;
                w_ctl.alu_src_b  = SRCB_RT;
                w_ctl.alu_op     = ALUOP_SUB;
                w_ctl.pc_source  = PCSRC_ALUOUT;
                w_ctl.pc_cond_eq = (OP == OP_BEQ);
                w_ctl.pc_cond_ne = (OP == OP_BNE);
                w_ctl.instr_done = 1'b1;
            end
            S_JUMP: begin
                w_ctl.pc_write   = 1'b1;
                w_ctl.pc_source  = PCSRC_JUMP;
                w_ctl.instr_done = 1'b1;
            end
            S_JAL: begin
                w_ctl.pc_write   = 1'b1;
                w_ctl.pc_source  = PCSRC_JUMP;
                w_ctl.reg_dst    = RDST_RA;
                w_ctl.mem_to_reg = MTR_PC;
                w_ctl.reg_write  = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            default: ;
        endcase
        w_ctl.mem_timeout = w_expired;
        // Gate combinationally so strobes fall the instant reset asserts, not at the next edge.
        if (!reset) w_ctl = '0;
    end

    assign PCWrite       = w_ctl.pc_write;
    assign PCWriteCondEQ = w_ctl.pc_cond_eq;
    assign PCWriteCondNE = w_ctl.pc_cond_ne;
    assign IorD          = w_ctl.iord;
    assign MemRead       = w_ctl.mem_read;
    assign MemWrite      = w_ctl.mem_write;
    assign IRWrite       = w_ctl.ir_write;
    assign MemtoReg      = w_ctl.mem_to_reg;
    assign RegDst        = w_ctl.reg_dst;
    assign RegWrite      = w_ctl.reg_write;
    assign ALUSrcA       = w_ctl.alu_src_a;
    assign ALUSrcB       = w_ctl.alu_src_b;
    assign PCSource      = w_ctl.pc_source;
    assign ALUOp         = ALUOP_W'(w_ctl.alu_op);
    assign state_o       = reset ? r_state : 4'd0;
    assign instr_done    = w_ctl.instr_done;
    assign illegal_op    = w_ctl.illegal_op;
    assign mem_timeout   = w_ctl.mem_timeout;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multicycle control FSM: instance 0 has a 4-cycle memory timeout and JAL,
// instance 1 has no timeout and treats JAL as illegal.
module tb_multicycle_control_fsm;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, RD = 4'd3, WB = 4'd4, WR = 4'd5,
                           RX = 4'd6, RW = 4'd7, IX = 4'd8, IW = 4'd9, BR = 4'd10, JU = 4'd11,
                           JL = 4'd12;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, ceq, cne, iord, mrd, mwr, irw;
        logic [1:0] m2r, rdst;
        logic       rw, srca;
        logic [1:0] srcb, psrc;
        logic [2:0] aluop;
        logic       done, ill, tmo;
    } tctl_t;

    logic       clk;
    logic       reset;
    logic [5:0] OP;
    logic       mem_ready;

    logic       pcw [2], ceq [2], cne [2], iord [2], mrd [2], mwr [2], irw [2];
    logic       rw [2], srca [2], done [2], ill [2], tmo [2];
    logic [1:0] m2r [2], rdst [2], srcb [2], psrc [2];
    logic [2:0] aluop [2];
    logic [3:0] st [2];

    tctl_t exp_q [$];
    tctl_t obs_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_control_fsm #(
            .ALUOP_W     (3),
            .MEM_TIMEOUT ((g == 0) ? 4 : 0),
            .ENABLE_JAL  ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .OP            (OP),
            .mem_ready     (mem_ready),
            .PCWrite       (pcw[g]),
            .PCWriteCondEQ (ceq[g]),
            .PCWriteCondNE (cne[g]),
            .IorD          (iord[g]),
            .MemRead       (mrd[g]),
            .MemWrite      (mwr[g]),
            .IRWrite       (irw[g]),
            .MemtoReg      (m2r[g]),
            .RegDst        (rdst[g]),
            .RegWrite      (rw[g]),
            .ALUSrcA       (srca[g]),
            .ALUSrcB       (srcb[g]),
            .PCSource      (psrc[g]),
            .ALUOp         (aluop[g]),
            .state_o       (st[g]),
            .instr_done    (done[g]),
            .illegal_op    (ill[g]),
            .mem_timeout   (tmo[g])
        );
    end

    function automatic tctl_t observe(input int i);
        tctl_t o;
        o.st = st[i];     o.pcw = pcw[i];   o.ceq = ceq[i];   o.cne = cne[i];
        o.iord = iord[i]; o.mrd = mrd[i];   o.mwr = mwr[i];   o.irw = irw[i];
        o.m2r = m2r[i];   o.rdst = rdst[i]; o.rw = rw[i];     o.srca = srca[i];
        o.srcb = srcb[i]; o.psrc = psrc[i]; o.aluop = aluop[i];
        o.done = done[i]; o.ill = ill[i];   o.tmo = tmo[i];
        return o;
    endfunction

    // Output table for each state, written from the control-signal description.
    function automatic tctl_t spec_out(input logic [3:0] s, input logic [5:0] op, input logic rdy,
                                       input int inst, input bit etmo);
        tctl_t e;
        e = '0;
        e.st = s;
        e.aluop = 3'b010;
        e.tmo = etmo;
        case (s)
            FE: begin e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            DE: begin
                e.srcb = 2'b11;
                if (!(op inside {6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05,
                                 6'h02, 6'h03}) || (op == 6'h03 && inst == 1)) begin
                    e.ill = 1; e.done = 1;
                end
            end
            MA: begin e.srca = 1; e.srcb = 2'b10; end
            RD: begin e.iord = 1; e.mrd = 1; end
            WB: begin e.m2r = 2'b01; e.rw = 1; e.done = 1; end
            WR: begin e.iord = 1; e.mwr = 1; e.done = rdy; end
            RX: begin e.srca = 1; e.aluop = 3'b111; end
            RW: begin e.rdst = 2'b01; e.rw = 1; e.done = 1; end
            IX: begin
                e.srca = 1; e.srcb = 2'b10;
                e.aluop = (op == 6'h08) ? 3'b110 : (op == 6'h0c) ? 3'b011 :
                          (op == 6'h0d) ? 3'b101 : 3'b001;
            end
            IW: begin e.rw = 1; e.done = 1; end
            BR: begin
                e.srca = 1; e.aluop = 3'b100; e.psrc = 2'b01; e.done = 1;
                e.ceq = (op == 6'h04); e.cne = (op == 6'h05);
            end
            JU: begin e.pcw = 1; e.psrc = 2'b10; e.done = 1; end
            JL: begin
                e.pcw = 1; e.psrc = 2'b10; e.rdst = 2'b10; e.m2r = 2'b10; e.rw = 1; e.done = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Called at a falling edge: drive one cycle, record expected and observed, advance.
    task automatic step(input logic rdy, input logic [3:0] est, input int inst, input bit etmo);
        mem_ready = rdy;
        #2;
        exp_q.push_back(spec_out(est, OP, rdy, inst, etmo));
        obs_q.push_back(observe(inst));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        tctl_t e, o;
        #2;
        for (int i = 0; i < 2; i++) begin exp_q.push_back('0); obs_q.push_back(observe(i)); end
        @(posedge clk); #2;
        for (int i = 0; i < 2; i++) begin exp_q.push_back('0); obs_q.push_back(observe(i)); end
        @(negedge clk);
        reset = 1'b1;
        step(1, FE, 0, 0); step(1, DE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL reset: got %h want %h", o, e); end
        end
    endtask

    task automatic test_rtype();
        tctl_t e, o;
        do_reset(); OP = 6'h00;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, RX, 0, 0); step(1, RW, 0, 0);
        step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL rtype: got %h want %h", o, e); end
        end
    endtask

    task automatic test_itype();
        tctl_t e, o;
        logic [5:0] ops [4];
        ops = '{6'h08, 6'h0c, 6'h0d, 6'h0f};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            OP = ops[k];
            step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, IX, 0, 0); step(1, IW, 0, 0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL itype: got %h want %h", o, e); end
        end
    endtask

    task automatic test_lw_wait();
        tctl_t e, o;
        do_reset(); OP = 6'h23;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0);
        step(0, RD, 0, 0); step(0, RD, 0, 0); step(1, RD, 0, 0); step(1, WB, 0, 0);
        step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL lw_wait: got %h want %h", o, e); end
        end
    endtask

    task automatic test_sw();
        tctl_t e, o;
        do_reset(); OP = 6'h2b;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0); step(1, WR, 0, 0);
        step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL sw: got %h want %h", o, e); end
        end
    endtask

    task automatic test_branch_jump();
        tctl_t e, o;
        do_reset();
        OP = 6'h04; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, BR, 0, 0);
        OP = 6'h05; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, BR, 0, 0);
        OP = 6'h02; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, JU, 0, 0);
        OP = 6'h03; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, JL, 0, 0);
        step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL branch_jump: got %h want %h", o, e); end
        end
    endtask

    task automatic test_illegal();
        tctl_t e, o;
        do_reset(); OP = 6'h3f;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, FE, 0, 0);
        do_reset(); OP = 6'h03;
        step(1, FE, 1, 0); step(1, DE, 1, 0); step(1, FE, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL illegal: got %h want %h", o, e); end
        end
    endtask

    task automatic test_timeout();
        tctl_t e, o;
        do_reset(); OP = 6'h2b;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0);
        for (int k = 0; k < 3; k++) step(0, WR, 0, 0);
        step(0, WR, 0, 1);
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0);
        for (int k = 0; k < 3; k++) step(0, WR, 0, 0);
        step(1, WR, 0, 0);
        for (int k = 0; k < 3; k++) step(0, FE, 0, 0);
        step(0, FE, 0, 1);
        OP = 6'h23;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0);
        for (int k = 0; k < 3; k++) step(0, RD, 0, 0);
        step(0, RD, 0, 1);
        step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL timeout: got %h want %h", o, e); end
        end
    endtask

    task automatic test_async_reset();
        tctl_t e, o;
        do_reset(); OP = 6'h2b;
        step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0); step(0, WR, 0, 0);
        mem_ready = 1'b0;
        #2;
        exp_q.push_back(spec_out(WR, OP, 1'b0, 0, 0)); obs_q.push_back(observe(0));
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin exp_q.push_back('0); obs_q.push_back(observe(i)); end
        @(negedge clk);
        reset = 1'b1;
        step(0, FE, 0, 0); step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL async_reset: got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        tctl_t e, o;
        do_reset();
        OP = 6'h00; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, RX, 0, 0); step(1, RW, 0, 0);
        OP = 6'h23; step(0, FE, 0, 0); step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0);
        step(1, RD, 0, 0); step(1, WB, 0, 0);
        OP = 6'h04; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, BR, 0, 0);
        OP = 6'h0c; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, IX, 0, 0); step(1, IW, 0, 0);
        OP = 6'h02; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, JU, 0, 0);
        OP = 6'h2b; step(1, FE, 0, 0); step(1, DE, 0, 0); step(1, MA, 0, 0); step(1, WR, 0, 0);
        step(1, FE, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL back_to_back: got %h want %h", o, e); end
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_ready = 1'b0;
        OP = 6'h00;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_wait();
        test_sw();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
